// File: rtl/qkv_fetch_arbiter.sv
// Round-robin arbiter/sequencer sharing one Q/K/V fetch unit among NUM_REQ consumers,
// with a watchdog that abandons a fetch the unit never completes.
module qkv_fetch_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   req_buf_sel,
  input  logic [NUM_REQ-1:0]     req_tiles_ctrl,
  input  logic [NUM_REQ-1:0]     req_restart,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   start_fetch,
  output logic                   reset_addr_counter,
  output logic [2:0]             Buffer_Select,
  output logic                   Tiles_Control,
  input  logic                   fetch_done,
  input  logic                   clear_err,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [CNT_WIDTH-1:0]   fetch_count,
  output logic [2:0]             state_dbg
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST_ADDR = 3'd1,
    S_START    = 3'd2,
    S_WAIT     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, owner, last_owner;
  logic               last_valid;
  logic [WD_W-1:0]    wd_cnt;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W:0]     cand;
  logic [NUM_REQ-1:0] win_onehot, owner_onehot;
  logic [2:0]         sel_buf;
  logic               sel_tiles, sel_restart;
  logic               need_rst, wd_max, timeout_hit;

  assign state_dbg = state;

  // Handshake: req is a level request held until done pulses for that requester,
  // which drops it on the edge sampling done=1; gnt stays high from grant through DONE.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!win_found && req[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    sel_buf      = '0;
    sel_tiles    = 1'b0;
    sel_restart  = 1'b0;
    win_onehot   = '0;
    owner_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        sel_buf       = req_buf_sel[3*i +: 3];
        sel_tiles     = req_tiles_ctrl[i];
        sel_restart   = req_restart[i];
        win_onehot[i] = 1'b1;
      end
      if (owner == PTR_W'(i)) owner_onehot[i] = 1'b1;
    end
  end

  // A new owner (or an unknown previous one) must not inherit the buffer address.
  assign need_rst = sel_restart || !last_valid || (win_idx != last_owner);
  assign wd_max   = (wd_cnt == WD_W'(TIMEOUT_CYCLES-1));

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    unique case (state)
      S_IDLE:     if (win_found) state_nxt = need_rst ? S_RST_ADDR : S_START;
      S_RST_ADDR: state_nxt = S_START;
      S_START:    state_nxt = S_WAIT;
      S_WAIT: begin
        if (fetch_done) begin
          state_nxt = S_DONE;
        end else if (wd_max) begin
          state_nxt   = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt                <= '0;
      done               <= '0;
      start_fetch        <= 1'b0;
      reset_addr_counter <= 1'b0;
      Buffer_Select      <= '0;
      Tiles_Control      <= 1'b0;
      busy               <= 1'b0;
      timeout_err        <= 1'b0;
      fetch_count        <= '0;
      rr_ptr             <= '0;
      owner              <= '0;
      last_owner         <= '0;
      last_valid         <= 1'b0;
      wd_cnt             <= '0;
    end else begin
      start_fetch        <= (state_nxt == S_START);
      reset_addr_counter <= (state_nxt == S_RST_ADDR);
      busy               <= (state_nxt != S_IDLE);
      done               <= (state_nxt == S_DONE) ? owner_onehot : '0;

      if (state == S_IDLE && win_found) begin
        owner         <= win_idx;
        gnt           <= win_onehot;
        Buffer_Select <= sel_buf;
        Tiles_Control <= sel_tiles;
      end else if (state_nxt == S_IDLE) begin
        gnt <= '0;
      end

      if (state == S_START)     wd_cnt <= '0;
      else if (state == S_WAIT) wd_cnt <= wd_cnt + WD_W'(1);

      if (state == S_DONE) begin
        rr_ptr      <= (owner == PTR_W'(NUM_REQ-1)) ? '0 : owner + PTR_W'(1);
        last_owner  <= owner;
        last_valid  <= 1'b1;
        fetch_count <= fetch_count + CNT_WIDTH'(1);
      end

      if (timeout_hit) begin
        last_valid  <= 1'b0;
        timeout_err <= 1'b1;
      end else if (clear_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qkv_fetch_arbiter.sv
// Directed plus randomized bench for qkv_fetch_arbiter against a transaction-level model
// of round-robin order, address-reset decisions, watchdog and completion counting.
module tb_qkv_fetch_arbiter;
  localparam int NREQ   = 3;
  localparam int TO_CYC = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, req_tiles_ctrl, req_restart;
  logic [8:0]  req_buf_sel;
  logic [2:0]  gnt, done;
  logic        start_fetch, reset_addr_counter;
  logic [2:0]  Buffer_Select;
  logic        Tiles_Control;
  logic        fetch_done, clear_err;
  logic        busy, timeout_err;
  logic [15:0] fetch_count;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // model state: rotation pointer, last completed owner (-1 = unknown), completions, error flag
  int m_rr, m_last, m_count;
  bit m_err;

  always #5 clk = ~clk;

  qkv_fetch_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TO_CYC), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_buf_sel(req_buf_sel),
    .req_tiles_ctrl(req_tiles_ctrl), .req_restart(req_restart), .gnt(gnt), .done(done),
    .start_fetch(start_fetch), .reset_addr_counter(reset_addr_counter),
    .Buffer_Select(Buffer_Select), .Tiles_Control(Tiles_Control), .fetch_done(fetch_done),
    .clear_err(clear_err), .busy(busy), .timeout_err(timeout_err),
    .fetch_count(fetch_count), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_last = -1; m_count = 0; m_err = 1'b0;
  endtask

  function automatic int model_winner(input logic [2:0] rq);
    for (int k = 0; k < NREQ; k++) begin
      int c = (m_rr + k) % NREQ;
      if (rq[c]) return c;
    end
    return -1;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},   32'(gnt), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_start"}, 32'(start_fetch), 32'd0);
    check({tag, "_rac"},   32'(reset_addr_counter), 32'd0);
    check({tag, "_bsel"},  32'(Buffer_Select), 32'd0);
    check({tag, "_tiles"}, 32'(Tiles_Control), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_err"},   32'(timeout_err), 32'd0);
    check({tag, "_count"}, 32'(fetch_count), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; fetch_done = 1'b0; clear_err = 1'b0;
    @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // Called at the negedge of an IDLE cycle (cycle 0); returns at the negedge of the
  // IDLE cycle that follows the transaction, with req dropped.
  task automatic fetch(input logic [2:0] rq, input logic [2:0] rs, input logic [8:0] bs,
                       input logic [2:0] tc, input int wc, input bit to, input bit noise,
                       output int w_obs);
    int w, lim;
    bit exp_rst;
    logic [2:0] gexp;
    w       = model_winner(rq);
    exp_rst = rs[w] || (w != m_last);
    gexp    = 3'(1 << w);
    req = rq; req_restart = rs; req_buf_sel = bs; req_tiles_ctrl = tc;
    fetch_done = noise;
    @(negedge clk);
    case (gnt)
      3'b001:  w_obs = 0;
      3'b010:  w_obs = 1;
      3'b100:  w_obs = 2;
      default: w_obs = -1;
    endcase
    check("c1_gnt",   32'(gnt), 32'(gexp));
    check("c1_bsel",  32'(Buffer_Select), 32'((bs >> (3*w)) & 9'd7));
    check("c1_tiles", 32'(Tiles_Control), 32'((tc >> w) & 3'd1));
    check("c1_rac",   32'(reset_addr_counter), 32'(exp_rst));
    check("c1_start", 32'(start_fetch), 32'(!exp_rst));
    check("c1_busy",  32'(busy), 32'd1);
    if (exp_rst) begin
      @(negedge clk);
      check("c2_start", 32'(start_fetch), 32'd1);
      check("c2_rac",   32'(reset_addr_counter), 32'd0);
    end
    lim = to ? TO_CYC : wc;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      fetch_done = (!to && k == wc);
      clear_err  = (to && k == TO_CYC);
      check("wait_done",  32'(done), 32'd0);
      check("wait_gnt",   32'(gnt), 32'(gexp));
      check("wait_start", 32'(start_fetch), 32'd0);
      check("wait_err",   32'(timeout_err), 32'(m_err));
    end
    @(negedge clk);
    fetch_done = 1'b0;
    clear_err  = 1'b0;
    if (!to) begin
      check("done_pulse", 32'(done), 32'(gexp));
      check("done_gnt",   32'(gnt), 32'(gexp));
      check("done_busy",  32'(busy), 32'd1);
      req = '0;
      @(negedge clk);
      m_count++;
      m_rr   = (w + 1) % NREQ;
      m_last = w;
    end else begin
      m_err  = 1'b1;
      m_last = -1;
      req    = '0;
    end
    check("end_gnt",   32'(gnt), 32'd0);
    check("end_busy",  32'(busy), 32'd0);
    check("end_done",  32'(done), 32'd0);
    check("end_start", 32'(start_fetch), 32'd0);
    check("end_rac",   32'(reset_addr_counter), 32'd0);
    check("end_count", 32'(fetch_count), 32'(m_count & 16'hffff));
    check("end_err",   32'(timeout_err), 32'(m_err));
  endtask

  initial begin
    int w;
    int rr_order[5] = '{0, 1, 2, 0, 1};
    rst_n = 1'b0; req = '0; req_buf_sel = '0; req_tiles_ctrl = '0; req_restart = '0;
    fetch_done = 1'b0; clear_err = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("init");
    rst_n = 1'b1;
    @(negedge clk);

    // first fetch: fetch_done in cycle 10 (8th WAIT cycle), done in 11, idle in 12
    fetch(3'b001, 3'b000, 9'd2, 3'b000, 8, 1'b0, 1'b0, w);
    // repeat owner without and with forced restart
    fetch(3'b001, 3'b000, 9'o5, 3'b001, 3, 1'b0, 1'b0, w);
    fetch(3'b001, 3'b001, 9'o3, 3'b000, 2, 1'b0, 1'b0, w);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      fetch(3'b111, 3'b000, 9'($urandom), 3'($urandom), int'($urandom_range(1, 6)), 1'b0, 1'b0, w);
      check("rr_order", 32'(w), 32'(rr_order[i]));
    end

    // watchdog expiry, then recovery with an address reset, then clear
    fetch(3'b010, 3'b000, 9'o123, 3'b010, 0, 1'b1, 1'b0, w);
    fetch(3'b010, 3'b000, 9'o456, 3'b000, 4, 1'b0, 1'b0, w);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    m_err = 1'b0;
    check("clear_err", 32'(timeout_err), 32'd0);

    // completion on the last permitted WAIT cycle
    fetch(3'b100, 3'b000, 9'o700, 3'b100, TO_CYC, 1'b0, 1'b0, w);

    // stray fetch_done while idle
    fetch_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_noise_busy",  32'(busy), 32'd0);
      check("idle_noise_done",  32'(done), 32'd0);
      check("idle_noise_count", 32'(fetch_count), 32'(m_count & 16'hffff));
    end
    fetch_done = 1'b0;
    // stray fetch_done during RST_ADDR/START
    fetch(3'b001, 3'b000, 9'o017, 3'b001, 5, 1'b0, 1'b1, w);
    fetch(3'b001, 3'b000, 9'o021, 3'b000, 5, 1'b0, 1'b1, w);

    for (int i = 0; i < 40; i++) begin
      fetch(3'($urandom_range(1, 7)), 3'($urandom), 9'($urandom), 3'($urandom),
            int'($urandom_range(1, TO_CYC)), ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), w);
      if (m_err && $urandom_range(0, 2) == 0) begin
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        m_err = 1'b0;
        check("rand_clear", 32'(timeout_err), 32'd0);
      end
    end

    // reset while WAIT is in progress
    req = 3'b001; req_restart = 3'b000; req_buf_sel = 9'o007; req_tiles_ctrl = 3'b001;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    fetch(3'b010, 3'b000, 9'o050, 3'b010, 3, 1'b0, 1'b0, w);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
